cipher_core_arbiter: RTL
========================

Name: cipher_core_arbiter

Overview:
Shares one gage_ingage_cipher core among NUM_REQ requesters.
- Grants access round-robin and latches the winner's key and plaintext.
- Issues a one-cycle start pulse, holds the core inputs stable until the core's done pulse, then returns the ciphertext to the winner over a valid/ready response handshake.
- Sits between requester ports (DMA, CPU mailbox) and the single cipher instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BLOCK_SIZE, 64, plaintext/ciphertext width; matches the core.
- KEY_SIZE, 64, key width; matches the core.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT; used only with CIPHER_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- req_key  in  NUM_REQ*KEY_SIZE  packed keys; requester i at slice [i*KEY_SIZE +: KEY_SIZE].
- req_data  in  NUM_REQ*BLOCK_SIZE  packed plaintexts, same slicing.
- rsp_valid  out  NUM_REQ  one-hot response valid.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_data  out  BLOCK_SIZE  ciphertext, shared by all requesters.
- rsp_err  out  1  response is a timeout error; tied 0 without the optional feature.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last grantee.
- core_start  out  1  start pulse to the core.
- core_key  out  KEY_SIZE  key to the core.
- core_plaintext  out  BLOCK_SIZE  plaintext to the core.
- core_ciphertext  in  BLOCK_SIZE  ciphertext from the core.
- core_done  in  1  core done pulse.
- core_reset  out  1  core abort pulse; tied 0 without the optional feature.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; req_ready, rsp_valid = 0; rsp_data, core_key, core_plaintext = 0; core_start, core_reset, rsp_err = 0; grant_id = 0; priority pointer = 0 (requester 0 highest); watchdog count = 0.
- Reset mid-operation: returns to IDLE next edge; any in-flight transaction is dropped with no response.
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - Winner = first asserted req_valid scanning ptr, ptr+1, ..., with wrap at NUM_REQ.
  - req_ready[winner] asserts combinationally in the same cycle, only in IDLE. The handshake completes in that cycle.
  - On that edge: latch req_key/req_data slices into core_key/core_plaintext, set grant_id=winner, go ISSUE.
  - No valid request: stay in IDLE.
- ISSUE: core_start=1 for exactly this cycle; go WAIT.
- WAIT:
  - core_key/core_plaintext held unchanged, because the core samples plaintext at completion.
  - On core_done=1: latch core_ciphertext into rsp_data, go RESPOND.
  - core_done seen in any other state is ignored.
- RESPOND:
  - rsp_valid[grant_id]=1; rsp_data stable until rsp_ready[grant_id]=1.
  - On accept: ptr = grant_id+1 (wrap to 0), go IDLE. rsp_valid drops next cycle.
  - rsp_ready from non-granted requesters is ignored.
- Throughput and latency:
  - Minimum 1 accept + 1 issue + core latency (3 cycles from start edge to done) + 1 respond cycle.
  - Next accept no earlier than the cycle after a response is taken; no overlap.
- Simultaneous requests: exactly one accepted per transaction. Losers keep req_valid asserted and must hold their data.
- Requester dropping req_valid while not granted: legal, no effect.

Optional Feature:
Macro: CIPHER_TIMEOUT_EN.
- With the macro defined:
  - The watchdog counts cycles in WAIT.
  - If count reaches TIMEOUT_CYCLES without core_done: pulse core_reset for 1 cycle, set rsp_data=0 and rsp_err=1, go RESPOND.
  - rsp_err clears when the response is accepted.
  - A core_done arriving on the same cycle as the timeout wins; no error.
- Without the macro: no counter is built; core_reset and rsp_err are tied 0; WAIT is unbounded.

Decomposition:
- Package cipher_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESPOND};
  - BLOCK_SIZE/KEY_SIZE default constants shared with the core;
  - the IDX_W = $clog2(NUM_REQ) helper function.
- One sub-module, rr_arbiter: combinational round-robin pick from req_valid and ptr. It outputs a one-hot grant plus an index and is reused by other shared-resource controllers.

Test Plan:
1. Single request:
   - Stimulus: req 1 with key 0x1122334455667788, data 0x0123456789ABCDEF.
   - Response: core_start pulses one cycle after accept; rsp_valid[1] with rsp_data 0xFEDCBA9876543210; grant_id=1.
2. All 4 requesters valid at once, from reset:
   - Service order 0,1,2,3, each response matching its own data's inverse.
   - Then requester 0 alone re-requests: granted after 3, no starvation.
3. Response backpressure:
   - Stimulus: hold rsp_ready[2]=0 for 10 cycles.
   - Response: rsp_valid[2] and rsp_data stable; no new req_ready; core_start not reasserted.
4. Hold check:
   - Stimulus: requester changes req_data to 0xFFFF... after accept, during WAIT.
   - Response: core_plaintext unchanged; ciphertext reflects the latched value.
5. Mid-transaction reset:
   - Stimulus: reset asserted in WAIT.
   - Response: next cycle all outputs at reset values, pointer 0, no rsp_valid.
6. Timeout (CIPHER_TIMEOUT_EN, TIMEOUT_CYCLES=8):
   - Stimulus: core stub never asserts done.
   - Response: core_reset pulses at WAIT cycle 8; rsp_err=1, rsp_data=0 to the grantee; subsequent request serviced normally.

Source files
------------

// File: rtl/cipher_arb_pkg.sv
// Shared types and constants for the cipher core arbiter and its round-robin picker.
package cipher_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

  // Block and key widths of the cipher core this arbiter fronts.
  localparam int DEF_BLOCK_SIZE = 64;
  localparam int DEF_KEY_SIZE   = 64;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req scanning ptr, ptr+1, ... with wrap.
// Produces a one-hot grant, the winner index, and an any-request flag.
module rr_arbiter
  import cipher_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from lowest priority to highest so the last hit written is the winner.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        grant = N'(1) << j;
        idx   = W'(j);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cipher_core_arbiter.sv
// Shares one cipher core among NUM_REQ requesters with round-robin arbitration.
// Optional watchdog in WAIT is built only when CIPHER_TIMEOUT_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request; winner accepted combinationally
// ISSUE   | one-cycle core_start pulse, core inputs already latched
// WAIT    | core running; key/plaintext held until core_done
// RESPOND | ciphertext (or timeout error) offered to the grantee
module cipher_core_arbiter
  import cipher_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int BLOCK_SIZE     = DEF_BLOCK_SIZE,
  parameter int KEY_SIZE       = DEF_KEY_SIZE,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*KEY_SIZE-1:0]    req_key,
  input  logic [NUM_REQ*BLOCK_SIZE-1:0]  req_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [BLOCK_SIZE-1:0]          rsp_data,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           core_start,
  output logic [KEY_SIZE-1:0]            core_key,
  output logic [BLOCK_SIZE-1:0]          core_plaintext,
  input  logic [BLOCK_SIZE-1:0]          core_ciphertext,
  input  logic                           core_done,
  output logic                           core_reset
);

  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_grant;
  logic               win_any;
  logic               rsp_accept;
  logic               timeout;

  rr_arbiter #(
    .N (NUM_REQ),
    .W (IDX_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign rsp_accept = rsp_ready[grant_id];
  assign busy       = (state != IDLE);

`ifdef CIPHER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  // A done arriving on the terminal cycle takes precedence over the timeout.
  assign timeout    = (state == WAIT) && !core_done && (wd_cnt == '0);
  assign core_reset = timeout;

  // Watchdog down-counter: loaded in ISSUE, terminal count in WAIT means timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == ISSUE) begin
      wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
    end else if ((state == WAIT) && (wd_cnt != '0)) begin
      wd_cnt <= wd_cnt - 1'b1;
    end
  end

  // Error flag set on timeout, cleared once the error response is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_err <= 1'b0;
    end else if (timeout) begin
      rsp_err <= 1'b1;
    end else if ((state == RESPOND) && rsp_accept) begin
      rsp_err <= 1'b0;
    end
  end
`else
  assign timeout    = 1'b0;
  assign core_reset = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake strobes.
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    rsp_valid  = '0;
    core_start = 1'b0;
    case (state)
      IDLE: begin
        if (win_any) begin
          req_ready = win_grant;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_done || timeout) begin
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        rsp_valid = NUM_REQ'(1) << grant_id;
        if (rsp_accept) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch winner inputs, capture result, advance priority after delivery.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_key       <= '0;
      core_plaintext <= '0;
      rsp_data       <= '0;
      grant_id       <= '0;
      ptr            <= '0;
    end else begin
      if ((state == IDLE) && win_any) begin
        core_key       <= req_key[int'(win_idx) * KEY_SIZE +: KEY_SIZE];
        core_plaintext <= req_data[int'(win_idx) * BLOCK_SIZE +: BLOCK_SIZE];
        grant_id       <= win_idx;
      end
      if ((state == WAIT) && core_done) begin
        rsp_data <= core_ciphertext;
      end else if (timeout) begin
        rsp_data <= '0;
      end
      if ((state == RESPOND) && rsp_accept) begin
        ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

endmodule
